// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer.
// Runs one req/ack fetch per PC value and buffers branch redirects until the PC can take them.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_busy,
  output logic               misalign_err
);

  typedef enum logic {FETCH, READY} state_t;

  state_t              state_reg;
  logic                req_reg;
  logic                instr_valid_reg;
  logic                misalign_reg;
  logic                pending_valid_reg;
  logic [ADDR_W-1:0]   pending_target_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [ADDR_W-1:0]   instr_pc_reg;
  logic [INSTR_W-1:0]  instr_reg;

  logic                redirect_aligned;
  logic                redirect_misaligned;
  logic                update_en;
  logic [ADDR_W-1:0]   pc_next;

  always_comb begin
    redirect_aligned    = redirect_valid && (redirect_target[1:0] == 2'b00);
    redirect_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
    update_en           = (state_reg == READY) && !hold;
    // A live redirect beats the buffered one; otherwise fall through to sequential.
    if (redirect_aligned)
      pc_next = redirect_target;
    else if (pending_valid_reg)
      pc_next = pending_target_reg;
    else
      pc_next = pc_reg + ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= FETCH;
      req_reg            <= 1'b0;
      instr_valid_reg    <= 1'b0;
      misalign_reg       <= 1'b0;
      pending_valid_reg  <= 1'b0;
      pending_target_reg <= '0;
      pc_reg             <= RESET_PC;
      instr_pc_reg       <= '0;
      instr_reg          <= '0;
    end else begin
      instr_valid_reg <= 1'b0;

      if (redirect_misaligned)
        misalign_reg <= 1'b1;

      case (state_reg)
        FETCH: begin
          // The request only counts as issued once req is visible, so an early ack is ignored.
          req_reg <= 1'b1;
          if (req_reg && imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
            req_reg         <= 1'b0;
            state_reg       <= READY;
          end
        end
        READY: begin
          if (!hold) begin
            pc_reg            <= pc_next;
            pending_valid_reg <= 1'b0;
            req_reg           <= 1'b1;
            state_reg         <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase

      if (!update_en && redirect_aligned) begin
        pending_valid_reg  <= 1'b1;
        pending_target_reg <= redirect_target;
      end
    end
  end

  // The PC only moves on the edge that re-enters FETCH, so it doubles as the held fetch address.
  assign imem_req     = req_reg;
  assign imem_addr    = pc_reg;
  assign fetch_busy   = req_reg;
  assign instr_valid  = instr_valid_reg;
  assign instr        = instr_reg;
  assign instr_pc     = instr_pc_reg;
  assign pc           = pc_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes expected {instr_pc, instr},
// a negedge monitor pops and compares on every instr_valid pulse.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hold;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        fetch_busy;
  logic        misalign_err;

  logic        hold2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic [31:0] pc2;
  logic        fetch_busy2;
  logic        misalign_err2;

  pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc(pc),
    .fetch_busy(fetch_busy), .misalign_err(misalign_err)
  );

  pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .hold(hold2),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .pc(pc2),
    .fetch_busy(fetch_busy2), .misalign_err(misalign_err2)
  );

  // hold source: either a static level or the PC-select FSM pattern 0,1,1
  logic       hold_mode   = 1'b0;
  logic       hold_static = 1'b1;
  logic [1:0] phase       = 2'd0;
  assign hold = hold_mode ? (phase != 2'd0) : hold_static;
  always @(negedge clk) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      chk("valid_not_back_to_back", {63'd0, prev_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr_valid: instr_pc 0x%08h, no fetch expected", instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("instr_pc", {32'd0, instr_pc}, {32'd0, mon_e[63:32]});
        chk("instr", {32'd0, instr}, {32'd0, mon_e[31:0]});
        $display("fetch pc=0x%08h instr=0x%08h", instr_pc, instr);
      end
    end
    prev_valid = instr_valid;
  end

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {63'd0, imem_req}, 64'd1);
    chk("imem_addr", {32'd0, imem_addr}, {32'd0, a});
    chk("pc", {32'd0, pc}, {32'd0, a});
    chk("fetch_busy", {63'd0, fetch_busy}, 64'd1);
  endtask

  task automatic start_fetch(input logic [31:0] a);
    wait_req(a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  task automatic stall(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("stall_req", {63'd0, imem_req}, 64'd1);
      chk("stall_addr", {32'd0, imem_addr}, {32'd0, a});
    end
  endtask

  task automatic finish_fetch(input logic rv, input logic [31:0] rt);
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("req_drop", {63'd0, imem_req}, 64'd0);
    redirect_valid  = rv;
    redirect_target = rt;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    hold2 = 1'b1;
    imem_ack2 = 1'b0;
    imem_rdata2 = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_instr_pc", {32'd0, instr_pc}, 64'd0);
    chk("rst_pc", {32'd0, pc}, 64'd0);
    chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
    chk("rst_pc_wrap", {32'd0, pc2}, 64'h0000_0000_FFFF_FFFC);
    rst = 1'b0;
    hold2 = 1'b0;

    // wraparound instance: 0xFFFFFFFC + 4 -> 0
    @(negedge clk);
    chk("wrap_req", {63'd0, imem_req2}, 64'd1);
    chk("wrap_addr0", {32'd0, imem_addr2}, 64'h0000_0000_FFFF_FFFC);
    imem_ack2 = 1'b1;
    imem_rdata2 = 32'h1234_5678;
    @(negedge clk);
    imem_ack2 = 1'b0;
    chk("wrap_valid", {63'd0, instr_valid2}, 64'd1);
    chk("wrap_instr_pc", {32'd0, instr_pc2}, 64'h0000_0000_FFFF_FFFC);
    chk("wrap_instr", {32'd0, instr2}, 64'h0000_0000_1234_5678);
    chk("wrap_busy_idle", {63'd0, fetch_busy2}, 64'd0);
    @(negedge clk);
    chk("wrap_pc", {32'd0, pc2}, 64'd0);
    chk("wrap_addr1", {32'd0, imem_addr2}, 64'd0);
    chk("wrap_req_again", {63'd0, imem_req2}, 64'd1);
    chk("wrap_misalign", {63'd0, misalign_err2}, 64'd0);
    hold2 = 1'b1;

    // zero-wait sequential fetches
    hold_static = 1'b0;
    start_fetch(32'h0);  finish_fetch(1'b0, 32'h0);
    start_fetch(32'h4);  finish_fetch(1'b0, 32'h0);
    start_fetch(32'h8);  finish_fetch(1'b0, 32'h0);

    // hold=1 in READY keeps the PC
    start_fetch(32'hC);
    hold_static = 1'b1;
    finish_fetch(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_pc", {32'd0, pc}, 64'hC);
      chk("hold_req", {63'd0, imem_req}, 64'd0);
      chk("hold_busy", {63'd0, fetch_busy}, 64'd0);
      @(negedge clk);
    end
    hold_static = 1'b0;
    start_fetch(32'h10); finish_fetch(1'b0, 32'h0);

    // PC-select pattern with one wait state per fetch
    hold_mode = 1'b1;
    start_fetch(32'h14); stall(32'h14, 1); finish_fetch(1'b0, 32'h0);
    start_fetch(32'h18); stall(32'h18, 1); finish_fetch(1'b0, 32'h0);
    start_fetch(32'h1C); stall(32'h1C, 1); finish_fetch(1'b0, 32'h0);
    hold_mode = 1'b0;

    // redirect during a stalled fetch is buffered
    start_fetch(32'h20);
    pulse(32'h100);
    stall(32'h20, 4);
    finish_fetch(1'b0, 32'h0);
    start_fetch(32'h100);
    pulse(32'h180);
    pulse(32'h200);
    stall(32'h100, 1);
    finish_fetch(1'b0, 32'h0);
    // live redirect on the update edge beats and clears the pending one
    start_fetch(32'h200);
    pulse(32'h300);
    finish_fetch(1'b1, 32'h400);
    start_fetch(32'h400);
    finish_fetch(1'b0, 32'h0);

    // misaligned redirects are dropped and flagged
    start_fetch(32'h404);
    pulse(32'h102);
    chk("misalign_set", {63'd0, misalign_err}, 64'd1);
    finish_fetch(1'b0, 32'h0);
    start_fetch(32'h408);
    pulse(32'h40);
    pulse(32'h102);
    chk("misalign_sticky", {63'd0, misalign_err}, 64'd1);
    finish_fetch(1'b0, 32'h0);
    wait_req(32'h40);
    chk("misalign_still", {63'd0, misalign_err}, 64'd1);

    // reset mid-fetch with a simultaneous ack
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    chk("midrst_req", {63'd0, imem_req}, 64'd0);
    chk("midrst_busy", {63'd0, fetch_busy}, 64'd0);
    chk("midrst_instr", {32'd0, instr}, 64'd0);
    chk("midrst_instr_pc", {32'd0, instr_pc}, 64'd0);
    chk("midrst_pc", {32'd0, pc}, 64'd0);
    chk("midrst_misalign", {63'd0, misalign_err}, 64'd0);
    @(negedge clk);
    chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
    chk("midrst_instr2", {32'd0, instr}, 64'd0);
    rst = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    wait_req(32'h0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
